// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and iteration constants for seq_mult32
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int SEQ_MULT_ITER  = 32;
  localparam int SEQ_MULT_CNT_W = 5;

endpackage

// File: rtl/mult_add_shift.sv
// rtl/mult_add_shift.sv - one radix-2 shift-and-add step; the add carry-out becomes the new top bit
module mult_add_shift #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      sum = {1'b0, acc_hi} + {1'b0, mcand};
    end
    {acc_hi_nxt, acc_lo_nxt} = {sum, acc_lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_mult32.sv
// rtl/seq_mult32.sv - multi-cycle 32x32->64 shift-and-add multiplier with start/busy/done handshake
// Signed operation (abs-value capture + FIX negation) is built only with SEQ_MULT_SIGNED_EN defined.
module seq_mult32
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          mcand_q, mcand_d;
  logic [WIDTH-1:0]          acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]          acc_lo_q, acc_lo_d;
  logic [SEQ_MULT_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0]        product_q, product_d;

  logic [WIDTH-1:0]          cap_mcand;
  logic [WIDTH-1:0]          cap_lo;
  logic [WIDTH-1:0]          nxt_hi;
  logic [WIDTH-1:0]          nxt_lo;
  logic                      last_iter;

`ifdef SEQ_MULT_SIGNED_EN
  logic                      neg_q, neg_d;
  logic                      cap_neg;
  logic [2*WIDTH-1:0]        acc_neg;

  // |0x80000000| wraps to itself, which is the correct magnitude read as unsigned.
  assign cap_mcand = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign cap_lo    = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign cap_neg   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign acc_neg   = ~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1);
`else
  logic                      unused_signed_op;

  assign cap_mcand        = a;
  assign cap_lo           = b;
  assign unused_signed_op = signed_op;
`endif

  mult_add_shift #(.WIDTH(WIDTH)) u_step (
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .mcand      (mcand_q),
    .acc_hi_nxt (nxt_hi),
    .acc_lo_nxt (nxt_lo)
  );

  assign last_iter = (cnt_q == SEQ_MULT_CNT_W'(SEQ_MULT_ITER - 1));

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = cap_mcand;
          acc_hi_d = '0;
          acc_lo_d = cap_lo;
          cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d    = cap_neg;
`endif
        end
      end
      S_RUN: begin
        acc_hi_d = nxt_hi;
        acc_lo_d = nxt_lo;
        cnt_d    = cnt_q + SEQ_MULT_CNT_W'(1);
        if (last_iter) begin
`ifdef SEQ_MULT_SIGNED_EN
          if (neg_q) begin
            state_d = S_FIX;
          end else begin
            state_d   = S_DONE;
            product_d = {nxt_hi, nxt_lo};
          end
`else
          state_d   = S_DONE;
          product_d = {nxt_hi, nxt_lo};
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      S_FIX: begin
        {acc_hi_d, acc_lo_d} = acc_neg;
        product_d            = acc_neg;
        state_d              = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult32.sv
// tb/tb_seq_mult32.sv - self-checking bench for seq_mult32 (follows SEQ_MULT_SIGNED_EN if defined)
module tb_seq_mult32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mult32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
`ifdef SEQ_MULT_SIGNED_EN
    if (s) return sx * sy;
`endif
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
`ifdef SEQ_MULT_SIGNED_EN
    if (s && (x[31] ^ y[31])) return 34;
`endif
    return 33;
  endfunction

  // Reference: an accepted start fixes the result and how many edges later done appears.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_product = '0;
  logic [63:0] m_pend = '0;
  int          m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_product <= '0;
      m_rem     <= 0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy    <= 1'b0;
        m_done    <= 1'b1;
        m_product <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_pend <= exp_prod(a, b, signed_op);
        m_rem  <= exp_lat(a, b, signed_op) - 1;
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (busy !== m_busy || done !== m_done || product !== m_product) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t: busy=%b done=%b product=%h, required busy=%b done=%b product=%h",
               $time, busy, done, product, m_busy, m_done, m_product);
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
    start     = 1'b1;
    a         = x;
    b         = y;
    signed_op = s;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    a         = $urandom;
    b         = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  // Edge count including E0 at which done is first seen.
  task automatic wait_done(input int n0, output int lat);
    int n;
    n = n0;
    while (!done && n < 80) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    lat = n;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [63:0] exp_p, input int exp_l);
    int lat;
    launch(x, y, s);
    wait_done(1, lat);
    check_int({name, "_latency"}, lat, exp_l);
    check64({name, "_product"}, product, exp_p);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int ndone;
    #200000;
    $display("FAIL watchdog: simulation did not end, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    repeat (2) @(negedge clk);
    check64("reset_product", product, 64'd0);
    check_int("reset_busy_done", {busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 33);
    run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33);
`ifdef SEQ_MULT_SIGNED_EN
    run_op("s_m7x6", 32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 34);
    run_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 33);
    run_op("s_5xm3", 32'd5, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 34);
`else
    run_op("s_m7x6", 32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'h0000_0005_FFFF_FFD6, 33);
    run_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, 33);
`endif
    run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33);

    // start mid-run with different operands must be ignored
    launch(32'd1000, 32'd1000, 1'b0);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; a = 32'd7; b = 32'd9;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check64("midrun_hold_product", product, 64'h4000_0000_0000_0000);
    wait_done(7, lat);
    check_int("midrun_latency", lat, 33);
    check64("midrun_product", product, 64'd1000000);

    // back-to-back: start during the done cycle
    launch(32'd6, 32'd7, 1'b0);
    check_int("b2b_busy", busy, 1);
    check64("b2b_hold_product", product, 64'd1000000);
    wait_done(1, lat);
    check_int("b2b_latency", lat, 33);
    check64("b2b_product", product, 64'd42);
    @(negedge clk);

    // reset during iteration 10
    launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_int("rst_busy", busy, 0);
    check_int("rst_done", done, 0);
    check64("rst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_int("rst_no_done", ndone, 0);

    run_op("u_post_rst", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
